// File: rtl/rv_constants.sv
// Shared rvsimple constants: ALU function codes plus the serial_alu state and shift-mode types.
package rv_constants;

  localparam int ALU_FUNCTION_WIDTH = 5;

  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_ADD  = 5'h00;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SUB  = 5'h01;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SLL  = 5'h02;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SLT  = 5'h03;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SLTU = 5'h04;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_XOR  = 5'h05;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SRL  = 5'h06;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SRA  = 5'h07;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_OR   = 5'h08;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_AND  = 5'h09;
  localparam logic [ALU_FUNCTION_WIDTH-1:0] ALU_SEQ  = 5'h0A;

  typedef enum logic [1:0] {
    SERIAL_ALU_IDLE,
    SERIAL_ALU_SHIFT,
    SERIAL_ALU_DONE
  } serial_alu_state_e;

  typedef enum logic [1:0] {
    SHIFT_LEFT_LOGIC,
    SHIFT_RIGHT_LOGIC,
    SHIFT_RIGHT_ARITH
  } shift_mode_e;

  function automatic logic is_shift(input logic [ALU_FUNCTION_WIDTH-1:0] fn);
    return (fn == ALU_SLL) || (fn == ALU_SRL) || (fn == ALU_SRA);
  endfunction

endpackage

// File: rtl/serial_alu_shifter.sv
// Result register for serial_alu: a one-bit-per-step shift register with down-counter, or a
// barrel shifter applied at load time when SERIAL_ALU_FAST_SHIFT_EN is defined.
module serial_alu_shifter
  import rv_constants::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  input  logic [SHAMT_W-1:0] load_shamt,
  input  shift_mode_e        load_mode,
  input  logic               step,
  output logic [WIDTH-1:0]   value,
  output logic               last
);

  logic [WIDTH-1:0] value_q;

  assign value = value_q;

`ifdef SERIAL_ALU_FAST_SHIFT_EN

  logic [WIDTH-1:0] barrel;
  logic             unused_step;

  assign unused_step = step;
  assign last        = 1'b0;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    barrel = load_value;
    case (load_mode)
      SHIFT_LEFT_LOGIC:  barrel = load_value << load_shamt;
      SHIFT_RIGHT_LOGIC: barrel = load_value >> load_shamt;
      SHIFT_RIGHT_ARITH: barrel = $signed(load_value) >>> load_shamt;
      default:           barrel = load_value;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= barrel;
    end
  end

`else

  logic [SHAMT_W-1:0] count_q;
  shift_mode_e        mode_q;

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v, input shift_mode_e m);
    case (m)
      SHIFT_LEFT_LOGIC:  return {v[WIDTH-2:0], 1'b0};
      SHIFT_RIGHT_LOGIC: return {1'b0, v[WIDTH-1:1]};
      default:           return {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  // The owning FSM leaves SHIFT on the step that takes the counter from 1 to 0.
  assign last = (count_q == SHAMT_W'(1));

  // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '0;
      count_q <= '0;
      mode_q  <= SHIFT_LEFT_LOGIC;
    end else if (load) begin
      value_q <= load_value;
      count_q <= load_shamt;
      mode_q  <= load_mode;
    end else if (step && (count_q != '0)) begin
      value_q <= shift_one(value_q, mode_q);
      count_q <= count_q - SHAMT_W'(1);
    end
  end

`endif

endmodule

// File: rtl/serial_alu.sv
// Multicycle ALU with request/response handshakes; shifts run serially unless
// SERIAL_ALU_FAST_SHIFT_EN is defined, in which case every op has latency 1.
module serial_alu
  import rv_constants::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
  input  logic [WIDTH-1:0]              operand_a,
  input  logic [WIDTH-1:0]              operand_b,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [WIDTH-1:0]              result,
  output logic                          result_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);

  serial_alu_state_e  state_q, state_d;
  logic               load, step, shift_last, op_is_shift;
  logic [SHAMT_W-1:0] shamt, load_shamt;
  logic [WIDTH-1:0]   alu_value;
  shift_mode_e        load_mode;

  assign shamt       = operand_b[SHAMT_W-1:0];
  assign op_is_shift = is_shift(alu_function);
  assign load_shamt  = op_is_shift ? shamt : '0;

  // Shift ops load operand_a and let the shifter do the rest; unknown codes resolve to 0.
  always_comb begin
    alu_value = '0;
    load_mode = SHIFT_LEFT_LOGIC;
    case (alu_function)
      ALU_ADD:  alu_value = operand_a + operand_b;
      ALU_SUB:  alu_value = operand_a - operand_b;
      ALU_SEQ:  alu_value = {{(WIDTH-1){1'b0}}, operand_a == operand_b};
      ALU_SLT:  alu_value = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      ALU_SLTU: alu_value = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
      ALU_XOR:  alu_value = operand_a ^ operand_b;
      ALU_OR:   alu_value = operand_a | operand_b;
      ALU_AND:  alu_value = operand_a & operand_b;
      ALU_SLL:  alu_value = operand_a;
      ALU_SRL: begin
        alu_value = operand_a;
        load_mode = SHIFT_RIGHT_LOGIC;
      end
      ALU_SRA: begin
        alu_value = operand_a;
        load_mode = SHIFT_RIGHT_ARITH;
      end
      default:  alu_value = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      SERIAL_ALU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load = 1'b1;
`ifdef SERIAL_ALU_FAST_SHIFT_EN
          state_d = SERIAL_ALU_DONE;
`else
          state_d = (op_is_shift && (shamt != '0)) ? SERIAL_ALU_SHIFT : SERIAL_ALU_DONE;
`endif
        end
      end
      SERIAL_ALU_SHIFT: begin
        step = 1'b1;
        if (shift_last) state_d = SERIAL_ALU_DONE;
      end
      SERIAL_ALU_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = SERIAL_ALU_IDLE;
      end
      default: state_d = SERIAL_ALU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= SERIAL_ALU_IDLE;
    else       state_q <= state_d;
  end

  serial_alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (alu_value),
    .load_shamt (load_shamt),
    .load_mode  (load_mode),
    .step       (step),
    .value      (result),
    .last       (shift_last)
  );

  assign result_zero = (result == '0);

endmodule

// File: doc/serial_alu.md
# serial_alu

Execution-side consumer of the 5-bit ALU function code produced by the ALU controller. Accepts one operation (function code, two XLEN operands) over a valid/ready handshake, computes it, and returns the result over a second valid/ready handshake. Shifts run one bit per cycle to save area; all other operations complete in one execute cycle. It sits between decode/operand-fetch and writeback in the multicycle rvsimple variant.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two; shift amount width is log2(WIDTH).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- alu_function  in  5  ALU function code (ALU_* constants).
- operand_a  in  WIDTH  first operand.
- operand_b  in  WIDTH  second operand; shift amount = operand_b[log2(WIDTH)-1:0].
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- result_zero  out  1  result == 0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: req_ready=1. On req_valid, latch function and operands.
  - Non-shift ops (ADD, SUB, SEQ, SLT, SLTU, XOR, OR, AND): compute into result register, go DONE.
  - Shift ops (SLL, SRL, SRA): load result register with operand_a, counter with shift amount; go SHIFT if amount != 0, else DONE.
  - Undefined code: result = 0, go DONE (never X).
- SHIFT: each cycle shift result register by one (SLL: zero-fill LSB; SRL: zero-fill MSB; SRA: replicate MSB), decrement counter; at counter reaching 0 after the shift, go DONE.
- DONE: resp_valid=1, result/result_zero stable. On resp_ready, go IDLE.
- Arithmetic: ADD/SUB modulo 2^WIDTH; SLT signed, SLTU unsigned; SEQ/SLT/SLTU produce 0 or 1 zero-extended.
- req_ready=1 only in IDLE; resp_valid=1 only in DONE. No request accepted in the cycle a response is consumed.
- Input operands need not be held after acceptance.

## Timing
- Reset: state IDLE, req_ready=1, resp_valid=0, result=0, result_zero=1, counter=0.
- Reset mid-operation (SHIFT or DONE): in-flight op discarded, outputs at reset values next cycle, no response issued.
- Request accepted at edge N: non-shift or shift-by-0 → resp_valid high from cycle N+1. Shift by k → resp_valid high from cycle N+1+k (max N+WIDTH).
- Response held indefinitely while resp_ready=0.
- Earliest back-to-back: accept at N, respond N+1, consumed at N+1 edge, next accept at N+2 edge (throughput one op per 2 cycles minimum).

## Configuration
- SERIAL_ALU_FAST_SHIFT_EN defined: shifts computed by a barrel shifter in the IDLE accept cycle; SHIFT state never entered; all ops have latency 1.
- Undefined: serial shifting as above, latency 1+shift amount.
- Handshake behaviour otherwise identical in both builds.

## Structure
- ALU_* function codes come from the existing rv_constants package; no local redefinition.
- Add to rv_constants: state typedef (IDLE/SHIFT/DONE) for this block.
- One sub-module: serial_alu_shifter — holds result shift register and down-counter, with load/step/done signals; replaced by combinational barrel logic when SERIAL_ALU_FAST_SHIFT_EN is defined.

## Test plan
- Reset then ADD a=0x0000_0005, b=0xFFFF_FFFE → resp_valid at N+1, result=0x0000_0003, result_zero=0.
- SRA a=0x8000_0000, b=4 → resp_valid at N+5, result=0xF800_0000; SRL same operands → 0x0800_0000; SLL by 0 → result=a at N+1.
- SLT a=0xFFFF_FFFF, b=1 → 1; SLTU same → 0; SEQ a=b=0x1234 → 1; SUB a=b → 0 with result_zero=1.
- Backpressure: hold resp_ready=0 for 10 cycles after DONE → result stable, req_ready=0 throughout; release → IDLE next cycle.
- Reset asserted during SLL by 31 at shift step 10 → resp_valid never rises, outputs at reset values next cycle, new ADD accepted cleanly.
- Undefined function code 0x1F → result=0, result_zero=1 at N+1; with SERIAL_ALU_FAST_SHIFT_EN, SRA by 31 completes at N+1.
